// File: rtl/seq_pkg.sv
// ============================================================================
// Module   : seq_pkg
// Brief    : Shared transport states, the rest code and pattern bus indexing
//            for the step sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package seq_pkg;

    typedef enum logic [1:0] {
        ST_STOPPED = 2'd0,
        ST_RUNNING = 2'd1,
        ST_PAUSED  = 2'd2
    } seq_state_e;

    localparam int NOTE_REST = 0;

    // Bit offset of the note for channel ch, step step in the flat pattern bus.
    function automatic int pat_offset(input int ch, input int step,
                                      input int note_w, input int num_steps);
        return (ch * num_steps + step) * note_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seq_step_timer.sv
// ============================================================================
// Module   : seq_step_timer
// Brief    : Per-step tick counter with step-duration latch and gate window.
//            Optional swing (SEQ_SWING_EN) lengthens even / shortens odd steps.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seq_step_timer
    import seq_pkg::*;
#(
    parameter int TICK_W   = 24,
    parameter int GATE_GAP = 12000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              load,
    input  logic              advance,
`ifdef SEQ_SWING_EN
    input  logic              load_odd,
    input  logic [TICK_W-2:0] swing_ticks,
`endif
    input  logic [TICK_W-1:0] step_ticks,
    output logic              terminal,
    output logic              tick_zero,
    output logic              gate_win
);

    // One spare bit so an even step of eff_ticks+swing cannot overflow.
    localparam int DW = TICK_W + 1;

    logic [DW-1:0] tick_q, tick_d;
    logic [DW-1:0] dur_q, dur_d;
    logic [DW-1:0] eff_ticks;
    logic [DW-1:0] load_dur;

    assign eff_ticks = (step_ticks < TICK_W'(2)) ? DW'(2) : {1'b0, step_ticks};

`ifdef SEQ_SWING_EN
    logic [DW-1:0] swing_ext;
    logic [DW-1:0] swing_clamped;

    always_comb begin
        swing_ext     = DW'(swing_ticks);
        swing_clamped = (swing_ext > (eff_ticks >> 1)) ? (eff_ticks >> 1) : swing_ext;
        load_dur      = load_odd ? (eff_ticks - swing_clamped) : (eff_ticks + swing_clamped);
    end
`else
    assign load_dur = eff_ticks;
`endif

    always_comb begin
        tick_d = tick_q;
        dur_d  = dur_q;
        if (clear) begin
            tick_d = '0;
            dur_d  = '0;
        end else if (load) begin
            tick_d = '0;
            dur_d  = load_dur;
        end else if (advance) begin
            tick_d = tick_q + DW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q <= '0;
            dur_q  <= '0;
        end else begin
            tick_q <= tick_d;
            dur_q  <= dur_d;
        end
    end

    assign terminal  = (tick_q == dur_q - DW'(1));
    assign tick_zero = (tick_q == '0);
    // Window is judged on the tick about to be displayed; short steps keep tick 0.
    assign gate_win  = (tick_d == '0) ||
                       (({1'b0, tick_d} + (DW+1)'(GATE_GAP)) < {1'b0, dur_d});

endmodule

`default_nettype wire

// File: rtl/seq_engine.sv
// ============================================================================
// Module   : seq_engine
// Brief    : Multi-channel step sequencer with run/pause/stop transport and
//            registered note/gate outputs. Optional swing via SEQ_SWING_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seq_engine
    import seq_pkg::*;
#(
    parameter int NUM_CH    = 2,
    parameter int NUM_STEPS = 16,
    parameter int NOTE_W    = 4,
    parameter int TICK_W    = 24,
    parameter int GATE_GAP  = 12000
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic                              pause,
    input  logic                              stop,
    input  logic [TICK_W-1:0]                 step_ticks,
`ifdef SEQ_SWING_EN
    input  logic [TICK_W-2:0]                 swing_ticks,
`endif
    input  logic [NUM_CH*NUM_STEPS*NOTE_W-1:0] pattern,
    output logic [$clog2(NUM_STEPS)-1:0]      step_idx,
    output logic                              step_strobe,
    output logic                              bar_strobe,
    output logic [NUM_CH*NOTE_W-1:0]          note,
    output logic [NUM_CH-1:0]                 gate,
    output logic                              running
);

    localparam int SW = $clog2(NUM_STEPS);

    seq_state_e    state_q, state_d;
    logic [SW-1:0] step_q, step_d, step_next;
    logic          step_strobe_q, step_strobe_d;
    logic          bar_strobe_q, bar_strobe_d;
    logic          running_q, running_d;

    logic t_clear, t_load, t_advance;
    logic t_terminal, t_tick_zero, t_gate_win;
    logic note_load, note_clear, gate_en;

    seq_step_timer #(
        .TICK_W   (TICK_W),
        .GATE_GAP (GATE_GAP)
    ) u_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (t_clear),
        .load        (t_load),
        .advance     (t_advance),
`ifdef SEQ_SWING_EN
        .load_odd    (step_d[0]),
        .swing_ticks (swing_ticks),
`endif
        .step_ticks  (step_ticks),
        .terminal    (t_terminal),
        .tick_zero   (t_tick_zero),
        .gate_win    (t_gate_win)
    );

    assign step_next = (step_q == SW'(NUM_STEPS - 1)) ? '0 : step_q + SW'(1);

    always_comb begin
        state_d       = state_q;
        step_d        = step_q;
        step_strobe_d = 1'b0;
        bar_strobe_d  = 1'b0;
        t_clear       = 1'b0;
        t_load        = 1'b0;
        t_advance     = 1'b0;
        note_load     = 1'b0;
        note_clear    = 1'b0;
        gate_en       = 1'b0;
        case (state_q)
            ST_STOPPED: begin
                if (start && !stop) begin
                    state_d       = ST_RUNNING;
                    step_d        = '0;
                    t_load        = 1'b1;
                    note_load     = 1'b1;
                    gate_en       = 1'b1;
                    step_strobe_d = 1'b1;
                    bar_strobe_d  = 1'b1;
                end
            end
            ST_RUNNING: begin
                if (stop) begin
                    state_d    = ST_STOPPED;
                    step_d     = '0;
                    t_clear    = 1'b1;
                    note_clear = 1'b1;
                end else if (pause) begin
                    state_d = ST_PAUSED;
                end else if (t_terminal) begin
                    step_d        = step_next;
                    t_load        = 1'b1;
                    note_load     = 1'b1;
                    gate_en       = 1'b1;
                    step_strobe_d = 1'b1;
                    bar_strobe_d  = (step_next == '0);
                end else begin
                    t_advance = 1'b1;
                    gate_en   = 1'b1;
                end
            end
            ST_PAUSED: begin
                if (stop) begin
                    state_d    = ST_STOPPED;
                    step_d     = '0;
                    t_clear    = 1'b1;
                    note_clear = 1'b1;
                end else if (start) begin
                    // Resume re-enters the held tick; it is only a step start if that tick is 0.
                    state_d       = ST_RUNNING;
                    gate_en       = 1'b1;
                    step_strobe_d = t_tick_zero;
                    bar_strobe_d  = t_tick_zero && (step_q == '0);
                end
            end
            default: begin
                state_d    = ST_STOPPED;
                step_d     = '0;
                t_clear    = 1'b1;
                note_clear = 1'b1;
            end
        endcase
        running_d = (state_d == ST_RUNNING);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_STOPPED;
            step_q        <= '0;
            step_strobe_q <= 1'b0;
            bar_strobe_q  <= 1'b0;
            running_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            step_q        <= step_d;
            step_strobe_q <= step_strobe_d;
            bar_strobe_q  <= bar_strobe_d;
            running_q     <= running_d;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [NOTE_W-1:0] pat_step [NUM_STEPS];
        logic [NOTE_W-1:0] note_d, note_q;
        logic              gate_d, gate_q;

        for (genvar s = 0; s < NUM_STEPS; s++) begin : g_step
            assign pat_step[s] = pattern[pat_offset(c, s, NOTE_W, NUM_STEPS) +: NOTE_W];
        end

        always_comb begin
            note_d = note_q;
            if (note_clear) begin
                note_d = '0;
            end else if (note_load) begin
                note_d = pat_step[step_d];
            end
            gate_d = gate_en && (note_d != NOTE_W'(NOTE_REST)) && t_gate_win;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                note_q <= '0;
                gate_q <= 1'b0;
            end else begin
                note_q <= note_d;
                gate_q <= gate_d;
            end
        end

        assign note[c*NOTE_W +: NOTE_W] = note_q;
        assign gate[c]                  = gate_q;
    end

    assign step_idx    = step_q;
    assign step_strobe = step_strobe_q;
    assign bar_strobe  = bar_strobe_q;
    assign running     = running_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_engine.sv
// ============================================================================
// Module   : tb_seq_engine
// Brief    : Self-checking bench for seq_engine: per-cycle behavioural model
//            plus directed literal expectations and randomized transport.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_seq_engine;

    localparam int NUM_CH    = 2;
    localparam int NUM_STEPS = 4;
    localparam int NOTE_W    = 4;
    localparam int TICK_W    = 24;
    localparam int GATE_GAP  = 30;
    localparam int SW        = $clog2(NUM_STEPS);
    localparam int PW        = NUM_CH * NUM_STEPS * NOTE_W;

    logic              clk        = 1'b0;
    logic              rst_n      = 1'b0;
    logic              start      = 1'b0;
    logic              pause      = 1'b0;
    logic              stop       = 1'b0;
    logic [TICK_W-1:0] step_ticks = TICK_W'(10);
    logic [PW-1:0]     pattern    = '0;
`ifdef SEQ_SWING_EN
    logic [TICK_W-2:0] swing_ticks = '0;
`endif

    logic [SW-1:0]            step_idx;
    logic                     step_strobe;
    logic                     bar_strobe;
    logic [NUM_CH*NOTE_W-1:0] note;
    logic [NUM_CH-1:0]        gate;
    logic                     running;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    seq_engine #(
        .NUM_CH    (NUM_CH),
        .NUM_STEPS (NUM_STEPS),
        .NOTE_W    (NOTE_W),
        .TICK_W    (TICK_W),
        .GATE_GAP  (GATE_GAP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .pause       (pause),
        .stop        (stop),
        .step_ticks  (step_ticks),
`ifdef SEQ_SWING_EN
        .swing_ticks (swing_ticks),
`endif
        .pattern     (pattern),
        .step_idx    (step_idx),
        .step_strobe (step_strobe),
        .bar_strobe  (bar_strobe),
        .note        (note),
        .gate        (gate),
        .running     (running)
    );

    // ---------------- behavioural model ----------------
    // mode: 0 stopped, 1 running, 2 paused. Position = (step, tick within step).
    int              m_mode = 0;
    int              m_step = 0;
    int              m_tick = 0;
    int              m_dur  = 0;
    int              m_note [NUM_CH];
    bit              m_strobe = 0;
    bit              m_bar    = 0;
    bit [NUM_CH-1:0] m_gate   = '0;

    function automatic int note_at(int c, int s);
        return int'(pattern[(c*NUM_STEPS + s)*NOTE_W +: NOTE_W]);
    endfunction

    function automatic int step_len(int s);
        int eff = (int'(step_ticks) < 2) ? 2 : int'(step_ticks);
        int sw  = 0;
`ifdef SEQ_SWING_EN
        sw = int'(swing_ticks);
        if (sw > eff / 2) sw = eff / 2;
`endif
        return (s % 2 == 0) ? eff + sw : eff - sw;
    endfunction

    function automatic bit in_window(int t, int d);
        return (t == 0) || (t < d - GATE_GAP);
    endfunction

    task automatic model_begin_step(int s);
        m_step   = s;
        m_tick   = 0;
        m_dur    = step_len(s);
        for (int c = 0; c < NUM_CH; c++) m_note[c] = note_at(c, s);
        m_strobe = 1;
        m_bar    = (s == 0);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0; m_step = 0; m_tick = 0; m_dur = 0;
            for (int c = 0; c < NUM_CH; c++) m_note[c] = 0;
            m_strobe = 0; m_bar = 0; m_gate = '0;
        end else begin
            m_strobe = 0;
            m_bar    = 0;
            if (stop) begin
                m_mode = 0; m_step = 0; m_tick = 0;
                for (int c = 0; c < NUM_CH; c++) m_note[c] = 0;
            end else if (m_mode == 0) begin
                if (start) begin
                    m_mode = 1;
                    model_begin_step(0);
                end
            end else if (m_mode == 1) begin
                if (pause) m_mode = 2;
                else if (m_tick == m_dur - 1) model_begin_step((m_step + 1) % NUM_STEPS);
                else m_tick++;
            end else if (start) begin
                m_mode   = 1;
                m_strobe = (m_tick == 0);
                m_bar    = (m_tick == 0) && (m_step == 0);
            end
            for (int c = 0; c < NUM_CH; c++)
                m_gate[c] = (m_mode == 1) && (m_note[c] != 0) && in_window(m_tick, m_dur);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [NUM_CH*NOTE_W-1:0] exp_note;
            for (int c = 0; c < NUM_CH; c++) exp_note[c*NOTE_W +: NOTE_W] = NOTE_W'(m_note[c]);
            n_tests++;
            if (step_idx !== SW'(m_step) || step_strobe !== m_strobe || bar_strobe !== m_bar ||
                running !== (m_mode == 1) || note !== exp_note || gate !== m_gate) begin
                n_fail++;
                $display("FAIL model t=%0t step %0d/%0d strobe %b/%b bar %b/%b run %b/%b note %h/%h gate %b/%b (got/exp)",
                         $time, step_idx, m_step, step_strobe, m_strobe, bar_strobe, m_bar,
                         running, (m_mode == 1), note, exp_note, gate, m_gate);
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // which: 0 start, 1 pause, 2 stop, 3 stop+start
    task automatic pulse(input int which);
        @(posedge clk); #1;
        start = (which == 0) || (which == 3);
        pause = (which == 1);
        stop  = (which == 2) || (which == 3);
        @(posedge clk); #1;
        start = 1'b0; pause = 1'b0; stop = 1'b0;
    endtask

    task automatic restart(input int ticks);
        pulse(2);
        step_ticks = TICK_W'(ticks);
        pulse(0);
    endtask

    int s_cyc[$];
    int s_step[$];
    int s_note0[$];
    int s_bar[$];
    int s_ghi[$];
    int g_any;

    task automatic record(input int ncyc);
        s_cyc.delete(); s_step.delete(); s_note0.delete(); s_bar.delete(); s_ghi.delete();
        g_any = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (step_strobe) begin
                s_cyc.push_back(i);
                s_step.push_back(int'(step_idx));
                s_note0.push_back(int'(note[NOTE_W-1:0]));
                s_bar.push_back(int'(bar_strobe));
                s_ghi.push_back(0);
            end
            if (gate != '0) g_any++;
            if (gate[0] && s_ghi.size() > 0) s_ghi[s_ghi.size()-1]++;
        end
    endtask

    task automatic check_periods(input string name, input int exp_even, input int exp_odd, input int n);
        check({name, "_count"}, (s_cyc.size() >= n + 1) ? 1 : 0, 1);
        for (int i = 1; i <= n && i < s_cyc.size(); i++)
            check(name, s_cyc[i] - s_cyc[i-1], (i % 2 == 1) ? exp_even : exp_odd);
    endtask

    initial begin
        int exp_step [5] = '{0, 1, 2, 3, 0};
        int exp_n0   [5] = '{1, 0, 3, 5, 1};
        int exp_bar  [5] = '{1, 0, 0, 0, 1};

        pattern[15:0]  = 16'h5301;   // ch0 steps {1,0,3,5}
        pattern[31:16] = 16'h7042;   // ch1 steps {2,4,0,7}

        repeat (3) @(posedge clk);
        #1;
        check("reset_step_idx", int'(step_idx), 0);
        check("reset_running", int'(running), 0);
        check("reset_gate", int'(gate), 0);
        check("reset_note", int'(note), 0);
        check("reset_strobe", int'(step_strobe), 0);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // basic stepping, eff_ticks=10 (<= gap: gate on tick 0 only)
        step_ticks = TICK_W'(10);
        pulse(0);
        record(45);
        check_periods("period10", 10, 10, 4);
        for (int i = 0; i < 5 && i < s_cyc.size(); i++) begin
            check("seq_step", s_step[i], exp_step[i]);
            check("seq_note0", s_note0[i], exp_n0[i]);
            check("seq_bar", s_bar[i], exp_bar[i]);
        end
        if (s_ghi.size() >= 2) begin
            check("gate_short_step0", s_ghi[0], 1);
            check("gate_rest_step1", s_ghi[1], 0);
        end

        // gate window with long steps, then short steps
        restart(100);
        record(400);
        check_periods("period100", 100, 100, 3);
        if (s_ghi.size() >= 3) begin
            check("gate_high_70_s0", s_ghi[0], 70);
            check("gate_high_70_s2", s_ghi[2], 70);
        end
        restart(20);
        record(45);
        check_periods("period20", 20, 20, 2);
        if (s_ghi.size() >= 1) check("gate_high_1", s_ghi[0], 1);

        // pause at step 2 tick 4, hold 50 cycles, resume
        restart(10);
        repeat (24) @(posedge clk);
        #1 pause = 1'b1;
        @(posedge clk);
        #1 pause = 1'b0;
        record(50);
        check("paused_strobes", s_cyc.size(), 0);
        check("paused_gate", g_any, 0);
        check("paused_running", int'(running), 0);
        check("paused_step", int'(step_idx), 2);
        pulse(0);
        record(20);
        check("resume_cycles_to_strobe", (s_cyc.size() > 0) ? s_cyc[0] : -1, 6);
        check("resume_next_step", (s_step.size() > 0) ? s_step[0] : -1, 3);

        // simultaneous stop+start while running
        pulse(3);
        @(negedge clk);
        check("stopstart_running", int'(running), 0);
        check("stopstart_step", int'(step_idx), 0);
        check("stopstart_gate", int'(gate), 0);
        check("stopstart_strobe", int'(step_strobe), 0);
        pulse(0);
        @(negedge clk);
        check("restart_strobe", int'(step_strobe), 1);
        check("restart_bar", int'(bar_strobe), 1);

        // step_ticks change mid-step applies at the next boundary
        restart(10);
        fork
            record(30);
            begin
                repeat (3) @(posedge clk);
                #1 step_ticks = TICK_W'(4);
            end
        join
        check("tick_change_cur", (s_cyc.size() > 1) ? s_cyc[1] - s_cyc[0] : -1, 10);
        check("tick_change_next", (s_cyc.size() > 2) ? s_cyc[2] - s_cyc[1] : -1, 4);
        restart(0);
        record(12);
        check_periods("period_min2", 2, 2, 3);

`ifdef SEQ_SWING_EN
        swing_ticks = (TICK_W-1)'(5);
        restart(20);
        record(90);
        check_periods("swing5", 25, 15, 4);
        swing_ticks = (TICK_W-1)'(15);
        restart(20);
        record(90);
        check_periods("swing_clamp", 30, 10, 4);
        swing_ticks = '0;
`endif

        // randomized transport, pattern and tempo against the model
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk); #1;
            rst_n = 1'b1;
            start = ($urandom_range(0, 19) == 0);
            pause = ($urandom_range(0, 24) == 0);
            stop  = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 39) == 0) step_ticks = TICK_W'($urandom_range(0, 70));
            if ($urandom_range(0, 29) == 0) pattern = PW'({$urandom, $urandom});
`ifdef SEQ_SWING_EN
            if ($urandom_range(0, 49) == 0) swing_ticks = (TICK_W-1)'($urandom_range(0, 40));
`endif
            if ($urandom_range(0, 1499) == 0) rst_n = 1'b0;
        end
        @(posedge clk); #1;
        rst_n = 1'b1; start = 1'b0; pause = 1'b0; stop = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/seq_engine.md
Name: seq_engine

Overview:
- Multi-channel step sequencer core. It is the parametrised successor to the single-voice beat controller.
- It steps through a flat pattern bus at a runtime-programmable tempo and supports run/pause/stop transport.
- Each step it emits a registered note code and a gate per channel.
- The per-channel pwm decoder/generator pairs consume `note`/`gate` downstream. The UI/LED logic consumes `step_idx` and the strobes.

Parameters:
- NUM_CH, 2, number of independent voices (1..8).
- NUM_STEPS, 16, steps per pattern (power of two not required, >=2).
- NOTE_W, 4, bits per note code; code 0 = rest.
- TICK_W, 24, width of tempo/gate tick counters.
- GATE_GAP, 12000, clk cycles that the gate is held low at the end of each step (note separation).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse: begin from step 0 (STOPPED) or resume (PAUSED)
- pause  in  1  pulse: freeze at current position (RUNNING only)
- stop  in  1  pulse: return to STOPPED, position 0
- step_ticks  in  TICK_W  clk cycles per step; sampled at each step boundary
- pattern  in  NUM_CH*NUM_STEPS*NOTE_W  note for channel c, step s at bits [(c*NUM_STEPS+s)*NOTE_W +: NOTE_W]
- step_idx  out  $clog2(NUM_STEPS)  currently sounding step
- step_strobe  out  1  one-cycle pulse on the first cycle of every step
- bar_strobe  out  1  one-cycle pulse coincident with step_strobe when step_idx==0
- note  out  NUM_CH*NOTE_W  registered note per channel for the current step
- gate  out  NUM_CH  per-channel gate
- running  out  1  high in RUNNING

Behaviour:
- Reset (rst_n low, async): state=STOPPED; all counters 0; step_idx=0; note=0; gate=0; strobes=0; running=0.
- FSM states and transitions:
  - STOPPED: start -> RUNNING at step 0.
  - RUNNING: pause -> PAUSED; stop -> STOPPED.
  - PAUSED: start -> RUNNING, resuming with the tick count and step held; stop -> STOPPED.
- Simultaneous pulses: priority is stop > start > pause. Pulses that are illegal in the current state are ignored; for example, start in RUNNING does not restart.
- Start from STOPPED, first step:
  - The cycle after start is sampled, step_strobe=1, bar_strobe=1, step_idx=0.
  - In that same cycle, note = pattern step 0, and gate=1 for every channel whose note is nonzero.
- Step timing:
  - An internal tick counter counts 0..eff_ticks-1, where eff_ticks = max(step_ticks, 2) is latched at each boundary.
  - On terminal count: step_idx advances, wrapping NUM_STEPS-1 -> 0. step_strobe, note and the new gates all update in the same registered cycle.
  - The step_strobe period is exactly eff_ticks cycles.
- Gate timing:
  - Gate stays high while tick < eff_ticks - GATE_GAP.
  - If eff_ticks <= GATE_GAP, the gate is high for tick 0 only.
  - Rest steps (note 0) hold the gate low for the whole step; note still outputs 0.
- Pattern sampling: the pattern is sampled only at step boundaries. Mid-step changes take effect at the next step.
- step_ticks changes also take effect at the next boundary only.
- PAUSED:
  - tick counter and step_idx hold; gate forced 0; note holds; no strobes.
  - On resume, the gate recomputes from the held tick on the first RUNNING cycle. No strobe fires unless the held tick is 0.
- stop mid-step: the next cycle gives step_idx=0, note=0, gate=0, no strobe.
- Reset mid-operation behaves as stop, but asynchronously.
- All outputs are registered; no combinational path exists from inputs to outputs.

Optional Feature:
- Macro SEQ_SWING_EN.
- When defined:
  - Extra input port swing_ticks (TICK_W-1 bits) is added, clamped to eff_ticks/2.
  - Even steps last eff_ticks+swing and odd steps last eff_ticks-swing, so each pair keeps an average of eff_ticks.
  - The gate rule applies using each step's own duration.
- When undefined: the port is absent and all steps last eff_ticks.

Decomposition:
- seq_pkg holds:
  - the state enum (ST_STOPPED, ST_RUNNING, ST_PAUSED);
  - localparam NOTE_REST=0;
  - a function computing the pattern bit offset (ch, step, NOTE_W, NUM_STEPS).
- Sub-module seq_step_timer: tick counter, eff_ticks latch, swing duration select, terminal-count and gate-window outputs.
- Channel note/gate registers remain in seq_engine under a generate loop.

Test Plan:
1. Reset, then start with step_ticks=10, NUM_STEPS=4, ch0 pattern {1,0,3,5} -> step_strobe every 10 cycles; step_idx 0,1,2,3,0; bar_strobe on step 0 only; ch0 note 1,0,3,5; gate0 low through all of step 1.
2. step_ticks=100, GATE_GAP=30 -> each gate is high for 70 cycles then low for 30; with step_ticks=20, the gate is high for 1 cycle per step.
3. pause during step 2 at tick 4, wait 50 cycles, start -> no strobes and gate=0 while paused; step 2 completes after 6 further RUNNING cycles.
4. stop and start asserted in the same cycle while RUNNING -> STOPPED, step_idx=0, gate=0, running=0. start alone on the next cycle -> step 0 strobe.
5. Change step_ticks from 10 to 4 at tick 3 of a step; step_ticks=0 -> the current step still lasts 10 and the next lasts 4; step_ticks=0 gives 2-cycle steps.
6. With SEQ_SWING_EN, step_ticks=20, swing=5 -> step durations alternate 25,15; with swing=15, it clamps to 10 and durations alternate 30,10.
